// File: rtl/nand_logic_unit.sv
// Registered 8-function logic unit whose datapath is built only from 2-input nand gates; valid/ready handshake, latency 1.
// Optional self-test FSM (ports bist_start/busy/done/fail) enabled by defining NAND_LOGIC_UNIT_BIST_EN.
module nand_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef NAND_LOGIC_UNIT_BIST_EN
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_fail,
`endif
  output logic [WIDTH-1:0] y
);

  logic [2:0]       dp_op;
  logic [WIDTH-1:0] dp_a, dp_b, dp_y;
  logic [WIDTH-1:0] n_ab, n_a, n_b, t_a, t_b;
  logic [WIDTH-1:0] f_and, f_or, f_nor, f_xor, f_xnor, f_buf;
  logic             xfer;

  // Every function is derived per bit from the shared nand terms.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand u_nab  (n_ab[i],   dp_a[i],  dp_b[i]);
    nand u_and  (f_and[i],  n_ab[i],  n_ab[i]);
    nand u_na   (n_a[i],    dp_a[i],  dp_a[i]);
    nand u_nb   (n_b[i],    dp_b[i],  dp_b[i]);
    nand u_or   (f_or[i],   n_a[i],   n_b[i]);
    nand u_nor  (f_nor[i],  f_or[i],  f_or[i]);
    nand u_ta   (t_a[i],    dp_a[i],  n_ab[i]);
    nand u_tb   (t_b[i],    dp_b[i],  n_ab[i]);
    nand u_xor  (f_xor[i],  t_a[i],   t_b[i]);
    nand u_xnor (f_xnor[i], f_xor[i], f_xor[i]);
    nand u_buf  (f_buf[i],  n_a[i],   n_a[i]);
  end

  always_comb begin
    dp_y = f_buf;
    case (dp_op)
      3'd0:    dp_y = f_and;
      3'd1:    dp_y = f_or;
      3'd2:    dp_y = n_ab;
      3'd3:    dp_y = f_nor;
      3'd4:    dp_y = f_xor;
      3'd5:    dp_y = f_xnor;
      3'd6:    dp_y = n_a;
      default: dp_y = f_buf;
    endcase
  end

`ifdef NAND_LOGIC_UNIT_BIST_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_t;

  bist_state_t      state, state_nxt;
  logic [4:0]       vec_cnt;
  logic [WIDTH-1:0] ref_y;

  // Vector bits {op, a_bit, b_bit}; a/b bits fan out across the full width.
  always_comb begin
    dp_op = op;
    dp_a  = a;
    dp_b  = b;
    if (state == RUN) begin
      dp_op = vec_cnt[4:2];
      dp_a  = {WIDTH{vec_cnt[1]}};
      dp_b  = {WIDTH{vec_cnt[0]}};
    end
  end

  always_comb begin
    ref_y = dp_a;
    case (dp_op)
      3'd0:    ref_y = dp_a & dp_b;
      3'd1:    ref_y = dp_a | dp_b;
      3'd2:    ref_y = ~(dp_a & dp_b);
      3'd3:    ref_y = ~(dp_a | dp_b);
      3'd4:    ref_y = dp_a ^ dp_b;
      3'd5:    ref_y = ~(dp_a ^ dp_b);
      3'd6:    ref_y = ~dp_a;
      default: ref_y = dp_a;
    endcase
  end

  always_comb begin
    state_nxt = state;
    bist_busy = 1'b0;
    bist_done = 1'b0;
    case (state)
      IDLE: if (bist_start && !out_valid) state_nxt = RUN;
      RUN: begin
        bist_busy = 1'b1;
        if (vec_cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        bist_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec_cnt   <= 5'd0;
      bist_fail <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == RUN) begin
        vec_cnt   <= 5'd0;
        bist_fail <= 1'b0;
      end else if (state == RUN) begin
        vec_cnt <= vec_cnt + 5'd1;
        if (dp_y !== ref_y) bist_fail <= 1'b1;
      end
    end
  end

  assign in_ready = (!out_valid || out_ready) && !bist_busy;
`else
  assign dp_op    = op;
  assign dp_a     = a;
  assign dp_b     = b;
  assign in_ready = !out_valid || out_ready;
`endif

  assign xfer = in_valid && in_ready;

  // A new transfer wins over a plain accept, giving full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      y         <= dp_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand_logic_unit.sv
// Directed self-checking bench for nand_logic_unit (WIDTH=8); self-test steps run when NAND_LOGIC_UNIT_BIST_EN is defined.
module tb_nand_logic_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
`ifdef NAND_LOGIC_UNIT_BIST_EN
  logic       bist_start, bist_busy, bist_done, bist_fail;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nand_logic_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef NAND_LOGIC_UNIT_BIST_EN
    .bist_start(bist_start),
    .bist_busy (bist_busy),
    .bist_done (bist_done),
    .bist_fail (bist_fail),
`endif
    .y         (y)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] op_exp [8];

  initial begin
    op_exp[0] = 8'h05; op_exp[1] = 8'hAF; op_exp[2] = 8'hFA; op_exp[3] = 8'h50;
    op_exp[4] = 8'hAA; op_exp[5] = 8'h55; op_exp[6] = 8'h5A; op_exp[7] = 8'hA5;

    rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
`ifdef NAND_LOGIC_UNIT_BIST_EN
    bist_start = 1'b0;
`endif
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_y", y, 8'h00);
    @(negedge clk); @(negedge clk);
    chk("reset_hold_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    chk("idle_in_ready", in_ready, 1'b1);

    // Single AND transfer, latency 1
    in_valid = 1'b1; op = 3'd0; a = 8'hF0; b = 8'h3C;
    @(negedge clk);
    chk("and_out_valid", out_valid, 1'b1);
    chk("and_y", y, 8'h30);

    // All opcodes, back to back
    for (int k = 0; k < 8; k++) begin
      op = 3'(k); a = 8'hA5; b = 8'h0F;
      @(negedge clk);
      chk($sformatf("op%0d_y", k), y, op_exp[k]);
      chk($sformatf("op%0d_out_valid", k), out_valid, 1'b1);
    end

    // Accept without transfer: valid drops, y holds
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", out_valid, 1'b0);
    chk("drain_y_hold", y, 8'hA5);

    // Backpressure for 10 cycles
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h0F;
    @(negedge clk);
    chk("bp_first_y", y, 8'hF0);
    op = 3'd0; a = 8'hFF; b = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_y_hold", y, 8'hF0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("b2b_first_y", y, 8'hFF);
    chk("b2b_first_valid", out_valid, 1'b1);
    op = 3'd1; a = 8'h00; b = 8'h00;
    @(negedge clk);
    chk("b2b_second_y", y, 8'h00);
    chk("b2b_second_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain_valid", out_valid, 1'b0);

    // Asynchronous reset with a held result
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'h5A; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_y", y, 8'h5A);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_y", y, 8'h00);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_no_xfer_valid", out_valid, 1'b0);
    chk("rst_no_xfer_y", y, 8'h00);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b0);

`ifdef NAND_LOGIC_UNIT_BIST_EN
    begin
      int busy_cycles;
      chk("bist_idle_busy", bist_busy, 1'b0);
      chk("bist_idle_fail", bist_fail, 1'b0);
      bist_start = 1'b1;
      @(negedge clk);
      bist_start = 1'b0;
      busy_cycles = 0;
      while (bist_busy === 1'b1 && busy_cycles < 40) begin
        if (in_ready !== 1'b0) chk("bist_in_ready", in_ready, 1'b0);
        busy_cycles++;
        @(negedge clk);
      end
      chk("bist_busy_cycles", busy_cycles, 32);
      chk("bist_done_pulse", bist_done, 1'b1);
      chk("bist_fail_clear", bist_fail, 1'b0);
      chk("bist_y_untouched", y, 8'h00);
      @(negedge clk);
      chk("bist_done_one_cycle", bist_done, 1'b0);
      chk("bist_back_idle", bist_busy, 1'b0);

      // Start ignored while a result is held
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      bist_start = 1'b1;
      @(negedge clk);
      bist_start = 1'b0;
      chk("bist_ignored_busy", bist_busy, 1'b0);
      chk("bist_ignored_y", y, 8'h00);
      chk("bist_ignored_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nand_logic_unit.md
NAND_LOGIC_UNIT -- requirements
Module: nand_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  operand/opcode present.
REQ-005 The block SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-006 The block SHALL have port op  input  3  opcode.
REQ-007 The block SHALL have port a  input  WIDTH  operand A.
REQ-008 The block SHALL have port b  input  WIDTH  operand B.
REQ-009 The block SHALL have port out_valid  output  1  result register holds a valid result.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 The block SHALL have port y  output  WIDTH  registered result.

Function
REQ-012 All logic functions SHALL be built per bit from 2-input nand primitives only (generate loop), no behavioural operators in the datapath.
REQ-013 Opcode map SHALL be: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a; b is ignored for 6 and 7.
REQ-014 in_ready SHALL equal (!out_valid || out_ready) combinationally, forced to 0 while the self-test runs.
REQ-015 A transfer SHALL occur when in_valid && in_ready; y SHALL then load the function result at that clock edge and out_valid SHALL be 1 in the next cycle (latency 1).
REQ-016 While out_valid && !out_ready, y and out_valid SHALL hold stable.
REQ-017 Simultaneous output accept and input transfer SHALL load the new result with out_valid staying 1 (no bubble, full throughput).
REQ-018 Output accept with no input transfer SHALL clear out_valid next cycle; y SHALL hold its last value.

Reset
REQ-019 On rst high, out_valid SHALL clear to 0 and y to all-zeros immediately, independent of clk.
REQ-020 Reset mid-transaction SHALL discard the held result; no transfer is accepted while rst is high.
REQ-021 Self-test state, vector counter and flags SHALL reset to IDLE / 0.

Configuration
REQ-022 Macro NAND_LOGIC_UNIT_BIST_EN SHALL, when defined, add ports bist_start (input 1), bist_busy (output 1), bist_done (output 1), bist_fail (output 1) and a self-test FSM.
REQ-023 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN when bist_start=1 and out_valid=0, otherwise bist_start is ignored.
REQ-024 In RUN, a 5-bit counter SHALL sweep {op, a_bit, b_bit} 0..31, one vector per cycle, with a_bit/b_bit replicated across all WIDTH bits of the datapath inputs; bist_busy=1, y and out_valid unchanged.
REQ-025 Each cycle in RUN, the nand datapath output SHALL be compared to a behavioural reference; any mismatch SHALL set bist_fail, sticky until next IDLE->RUN.
REQ-026 After vector 31, RUN->DONE; DONE SHALL assert bist_done for exactly one cycle, then return to IDLE.
REQ-027 Without the macro, these ports and the FSM SHALL be absent and in_ready SHALL follow REQ-014 without the self-test term.

Verification
REQ-028 WIDTH=8, op=0, a=8'hF0, b=8'h3C, out_ready=1 -> y=8'h30, out_valid=1 one cycle after transfer.
REQ-029 All 8 opcodes with a=8'hA5, b=8'h0F -> y = 05, AF, FA, 50, AA, 55, 5A, A5 respectively.
REQ-030 out_ready=0 after one transfer -> in_ready=0, y held for 10 cycles; then out_ready=1 with new in_valid -> back-to-back results, no idle cycle.
REQ-031 rst asserted between clk edges while out_valid=1 -> out_valid=0, y=0 before next edge.
REQ-032 With NAND_LOGIC_UNIT_BIST_EN: bist_start pulse in IDLE -> bist_busy high 32 cycles, in_ready=0, bist_done one-cycle pulse, bist_fail=0; bist_start while out_valid=1 -> ignored.
